// File: rtl/cam_pkg.sv
// Shared definitions for the per-camera bounding-box extractor.
// Holds the default frame geometry, the hit-counter width, the FSM state
// encoding and the bbox_t record. bbox_t is laid out so that one extractor
// per camera can feed the disparity/colour block's per-camera box inputs.
package cam_pkg;

  localparam logic [11:0] H_ACT_DEF = 12'd1280;
  localparam logic [11:0] V_ACT_DEF = 12'd720;

  // Hit counter saturates at 2^HIT_CNT_W - 1.
  localparam int HIT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_ACCUM     = 2'd1,
    ST_LATCH     = 2'd2
  } cam_state_e;

  // Field widths match the default 1280x720 geometry.
  typedef struct packed {
    logic [10:0] start_x;
    logic [9:0]  start_y;
    logic [10:0] end_x;
    logic [9:0]  end_y;
    logic        found;
  } bbox_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Registered edge detector for the camera timing strobes.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   vsync, de : raw frame sync and active-pixel qualifier
//   vs_rise   : vsync & ~vs_d   (high in the first cycle vsync reads 1)
//   de_fall   : ~de & de_d      (high in the first cycle after a line ends)
module cam_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic vsync,
  input  logic de,
  output logic vs_rise,
  output logic de_fall
);

  logic vs_d_q, vs_d_d;
  logic de_d_q, de_d_d;

  always_comb begin
    vs_d_d = vsync;
    de_d_d = de;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d_q <= 1'b0;
      de_d_q <= 1'b0;
    end else begin
      vs_d_q <= vs_d_d;
      de_d_q <= de_d_d;
    end
  end

  assign vs_rise = vsync & ~vs_d_q;
  assign de_fall = ~de & de_d_q;

endmodule

// File: rtl/cam_bbox_extract.sv
// Per-camera bounding-box extractor.
// Tracks the pixel position of the incoming video stream and, over each
// frame, the extent of all pixels flagged by 'hit'. At every frame boundary
// (vsync rising edge) the extent of the frame just finished is published.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   vsync, de, hit       : video timing and per-pixel target match
//   start_x/end_x        : box columns   ($clog2(H_ACT) bits)
//   start_y/end_y        : box rows      ($clog2(V_ACT) bits)
//   found                : published box holds at least MIN_HITS pixels
//   box_valid            : one-cycle pulse when the outputs update
//   dbg_state            : current FSM state (cam_state_e encoding)
// Handshake: box_valid is a pure strobe with no back-pressure; the outputs
// are stable from the box_valid cycle until the next box_valid or reset.
module cam_bbox_extract
  import cam_pkg::*;
#(
  parameter logic [11:0] H_ACT    = H_ACT_DEF,
  parameter logic [11:0] V_ACT    = V_ACT_DEF,
  parameter int          MIN_HITS = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vsync,
  input  logic                     de,
  input  logic                     hit,
  output logic [$clog2(H_ACT)-1:0] start_x,
  output logic [$clog2(H_ACT)-1:0] end_x,
  output logic [$clog2(V_ACT)-1:0] start_y,
  output logic [$clog2(V_ACT)-1:0] end_y,
  output logic                     found,
  output logic                     box_valid,
  output logic [1:0]               dbg_state
);

  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);
  localparam logic [XW-1:0]        X_MAX      = XW'(H_ACT - 12'd1);
  localparam logic [YW-1:0]        Y_MAX      = YW'(V_ACT - 12'd1);
  localparam logic [HIT_CNT_W-1:0] HIT_MAX    = '1;
  localparam logic [HIT_CNT_W-1:0] MIN_HITS_C = HIT_CNT_W'(MIN_HITS);

  logic vs_rise, de_fall;

  cam_sync_edge u_sync_edge (
    .clk     (clk),
    .rstn    (rstn),
    .vsync   (vsync),
    .de      (de),
    .vs_rise (vs_rise),
    .de_fall (de_fall)
  );

  // Pixel position counters
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;

  always_comb begin
    x_cnt_d = x_cnt_q;
    if (de_fall) begin
      x_cnt_d = '0;
    end else if (de && (x_cnt_q != X_MAX)) begin
      x_cnt_d = x_cnt_q + 1'b1;
    end
  end

  // vsync clear wins over a coincident line end so a new frame starts at row 0.
  always_comb begin
    y_cnt_d = y_cnt_q;
    if (vs_rise) begin
      y_cnt_d = '0;
    end else if (de_fall && (y_cnt_q != Y_MAX)) begin
      y_cnt_d = y_cnt_q + 1'b1;
    end
  end

  // FSM, running extent and published box
  cam_state_e state_q, state_d;

  logic [XW-1:0]        run_min_x_q, run_min_x_d, run_max_x_q, run_max_x_d;
  logic [YW-1:0]        run_min_y_q, run_min_y_d, run_max_y_q, run_max_y_d;
  logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic [XW-1:0] start_x_q, start_x_d, end_x_q, end_x_d;
  logic [YW-1:0] start_y_q, start_y_d, end_y_q, end_y_d;
  logic          found_q, found_d;
  logic          box_valid_q, box_valid_d;
  logic          box_ok;

  always_comb begin
    state_d     = state_q;
    run_min_x_d = run_min_x_q;
    run_max_x_d = run_max_x_q;
    run_min_y_d = run_min_y_q;
    run_max_y_d = run_max_y_q;
    hit_cnt_d   = hit_cnt_q;
    start_x_d   = start_x_q;
    end_x_d     = end_x_q;
    start_y_d   = start_y_q;
    end_y_d     = end_y_q;
    found_d     = found_q;
    box_valid_d = 1'b0;
    box_ok      = (hit_cnt_q >= MIN_HITS_C);

    case (state_q)
      // Pixels before the first frame boundary belong to a partial frame.
      ST_WAIT_SYNC: begin
        if (vs_rise) state_d = ST_ACCUM;
      end

      ST_ACCUM: begin
        if (vs_rise) begin
          // The run registers are final here (a hit in this cycle is
          // dropped), so the box is registered on the way into LATCH and
          // becomes visible together with box_valid one cycle after the edge.
          state_d     = ST_LATCH;
          box_valid_d = 1'b1;
          found_d     = box_ok;
          if (box_ok) begin
            start_x_d = run_min_x_q;
            end_x_d   = run_max_x_q;
            start_y_d = run_min_y_q;
            end_y_d   = run_max_y_q;
          end else begin
            start_x_d = '0;
            end_x_d   = '0;
            start_y_d = '0;
            end_y_d   = '0;
          end
        end else if (de && hit) begin
          if (x_cnt_q < run_min_x_q) run_min_x_d = x_cnt_q;
          if (x_cnt_q > run_max_x_q) run_max_x_d = x_cnt_q;
          if (y_cnt_q < run_min_y_q) run_min_y_d = y_cnt_q;
          if (y_cnt_q > run_max_y_q) run_max_y_d = y_cnt_q;
          if (hit_cnt_q != HIT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
        end
      end

      // One-cycle state; a vsync edge here is not acted on.
      ST_LATCH: begin
        state_d     = ST_ACCUM;
        run_min_x_d = '1;
        run_max_x_d = '0;
        run_min_y_d = '1;
        run_max_y_d = '0;
        hit_cnt_d   = '0;
      end

      default: state_d = ST_WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_WAIT_SYNC;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      run_min_x_q <= '1;
      run_max_x_q <= '0;
      run_min_y_q <= '1;
      run_max_y_q <= '0;
      hit_cnt_q   <= '0;
      start_x_q   <= '0;
      end_x_q     <= '0;
      start_y_q   <= '0;
      end_y_q     <= '0;
      found_q     <= 1'b0;
      box_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      run_min_x_q <= run_min_x_d;
      run_max_x_q <= run_max_x_d;
      run_min_y_q <= run_min_y_d;
      run_max_y_q <= run_max_y_d;
      hit_cnt_q   <= hit_cnt_d;
      start_x_q   <= start_x_d;
      end_x_q     <= end_x_d;
      start_y_q   <= start_y_d;
      end_y_q     <= end_y_d;
      found_q     <= found_d;
      box_valid_q <= box_valid_d;
    end
  end

  assign start_x   = start_x_q;
  assign end_x     = end_x_q;
  assign start_y   = start_y_q;
  assign end_y     = end_y_q;
  assign found     = found_q;
  assign box_valid = box_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cam_bbox_extract.sv
// Bench for cam_bbox_extract: two instances (MIN_HITS 16 and 1) share one
// video stream; a pixel-level model predicts each published box.
module tb_cam_bbox_extract;
  import cam_pkg::*;

  localparam int HA    = 1280;
  localparam int VA    = 720;
  localparam int MIN_A = 16;
  localparam int MIN_B = 1;

  // Clock / reset
  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic vsync = 1'b0;
  logic de    = 1'b0;
  logic hit   = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] a_sx, a_ex, b_sx, b_ex;
  logic [9:0]  a_sy, a_ey, b_sy, b_ey;
  logic        a_found, b_found, a_bv, b_bv;
  logic [1:0]  a_st, b_st;

  cam_bbox_extract #(.MIN_HITS(MIN_A)) dut_a (
    .clk(clk), .rstn(rstn), .vsync(vsync), .de(de), .hit(hit),
    .start_x(a_sx), .end_x(a_ex), .start_y(a_sy), .end_y(a_ey),
    .found(a_found), .box_valid(a_bv), .dbg_state(a_st)
  );

  cam_bbox_extract #(.MIN_HITS(MIN_B)) dut_b (
    .clk(clk), .rstn(rstn), .vsync(vsync), .de(de), .hit(hit),
    .start_x(b_sx), .end_x(b_ex), .start_y(b_sy), .end_y(b_ey),
    .found(b_found), .box_valid(b_bv), .dbg_state(b_st)
  );

  // Scoreboard
  int    n_tests = 0;
  int    n_fail  = 0;
  bbox_t exp_a_q[$];
  bbox_t exp_b_q[$];
  int    exp_cyc_q[$];

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_box(string name, bbox_t act, bbox_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sx=%0d sy=%0d ex=%0d ey=%0d f=%0d, want sx=%0d sy=%0d ex=%0d ey=%0d f=%0d",
               name, act.start_x, act.start_y, act.end_x, act.end_y, act.found,
               exp.start_x, exp.start_y, exp.end_x, exp.end_y, exp.found);
    end
  endtask

  function automatic bbox_t pk(logic [10:0] sx, logic [9:0] sy,
                               logic [10:0] ex, logic [9:0] ey, logic f);
    bbox_t b;
    b.start_x = sx;
    b.start_y = sy;
    b.end_x   = ex;
    b.end_y   = ey;
    b.found   = f;
    return b;
  endfunction

  // Reference model: extent of hit pixels of the current frame
  bit armed = 1'b0;
  int line  = 0;
  int mnx, mny, mxx, mxy, hits;

  function automatic void model_clear();
    mnx  = 1 << 30;
    mny  = 1 << 30;
    mxx  = -1;
    mxy  = -1;
    hits = 0;
  endfunction

  function automatic void model_hit(int x, int y);
    if (x < mnx) mnx = x;
    if (x > mxx) mxx = x;
    if (y < mny) mny = y;
    if (y > mxy) mxy = y;
    if (hits < 65535) hits++;
  endfunction

  function automatic bbox_t mk_box(int thr);
    if (hits >= thr && hits > 0)
      return pk(11'(mnx), 10'(mny), 11'(mxx), 10'(mxy), 1'b1);
    return pk('0, '0, '0, '0, 1'b0);
  endfunction

  // Monitor
  bbox_t hold_a = '0;
  bbox_t hold_b = '0;

  always @(negedge clk) begin
    bbox_t act_a, act_b, ea, eb;
    int    c;
    act_a = pk(a_sx, a_sy, a_ex, a_ey, a_found);
    act_b = pk(b_sx, b_sy, b_ex, b_ey, b_found);
    if (!rstn) begin
      hold_a = '0;
      hold_b = '0;
    end else if (a_bv || b_bv) begin
      chk("bv_pair", int'(a_bv), int'(b_bv));
      if (exp_cyc_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_box: got box_valid=1 at cycle %0d, want no box", cyc);
      end else begin
        c  = exp_cyc_q.pop_front();
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        chk("box_latency", cyc, c);
        chk_box("box_a", act_a, ea);
        chk_box("box_b", act_b, eb);
        hold_a = ea;
        hold_b = eb;
      end
    end else begin
      chk_box("hold_a", act_a, hold_a);
      chk_box("hold_b", act_b, hold_b);
    end
  end

  // Driver tasks
  task automatic pixel(bit d, bit h, bit v);
    @(negedge clk);
    de    = d;
    hit   = h;
    vsync = v;
  endtask

  task automatic drive_line(int len, int lo, int hi, int pct, int blank);
    for (int i = 0; i < len; i++) begin
      bit h;
      h = (i >= lo) && (i <= hi) && ($urandom_range(1, 100) <= pct);
      pixel(1'b1, h, 1'b0);
      if (h && armed) model_hit((i < HA) ? i : HA - 1, (line < VA) ? line : VA - 1);
    end
    repeat (blank) pixel(1'b0, 1'b0, 1'b0);
    line++;
  endtask

  // coincident=1 puts a one-pixel hit line in the vsync edge cycle.
  task automatic frame_sync(bit coincident);
    int c;
    pixel(coincident, coincident, 1'b1);
    c = cyc;
    if (armed) begin
      exp_a_q.push_back(mk_box(MIN_A));
      exp_b_q.push_back(mk_box(MIN_B));
      exp_cyc_q.push_back(c + 1);
    end
    armed = 1'b1;
    model_clear();
    line = coincident ? 1 : 0;
    repeat (3) pixel(1'b0, 1'b0, 1'b1);
    repeat (2) pixel(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn  = 1'b0;
    de    = 1'b0;
    hit   = 1'b0;
    vsync = 1'b0;
    armed = 1'b0;
    line  = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic block_frame(int nlines, int len, int y0, int y1, int x0, int x1);
    for (int l = 0; l < nlines; l++) begin
      if (l >= y0 && l <= y1) drive_line(len, x0, x1, 100, 2);
      else                    drive_line(len, 1, 0, 0, 2);
    end
  endtask

  // Stimulus
  initial begin
    int nl, len, lo, hi;
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start_x", int'(a_sx), 0);
    chk("rst_start_y", int'(a_sy), 0);
    chk("rst_end_x",   int'(a_ex), 0);
    chk("rst_end_y",   int'(a_ey), 0);
    chk("rst_found",   int'(a_found), 0);
    chk("rst_box_valid", int'(a_bv), 0);
    chk("rst_state",   int'(a_st), int'(ST_WAIT_SYNC));
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // Partial first frame then a full frame; only the second is reported
    block_frame(90, 200, 50, 89, 100, 199);
    frame_sync(1'b0);
    block_frame(90, 200, 50, 89, 100, 199);
    frame_sync(1'b0);

    // Ten hits: below MIN_HITS for instance A
    drive_line(20, 5, 9, 100, 2);
    drive_line(20, 2, 6, 100, 2);
    frame_sync(1'b0);

    // Hit coincident with the vsync edge is excluded
    block_frame(14, 14, 10, 13, 10, 13);
    frame_sync(1'b1);
    block_frame(6, 20, 3, 5, 4, 18);
    frame_sync(1'b0);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(1, 12);
      for (int l = 0; l < nl; l++) begin
        len = $urandom_range(1, 48);
        lo  = $urandom_range(0, 47);
        hi  = $urandom_range(lo, 47);
        drive_line(len, lo, hi, $urandom_range(0, 100), $urandom_range(1, 4));
      end
      frame_sync(1'b0);
    end

    // Column saturation: 1400-pixel line, hit on the last pixel
    drive_line(1400, 1399, 1399, 100, 2);
    drive_line(20, 0, 15, 100, 2);
    frame_sync(1'b0);

    // Single hit at the bottom-right corner
    for (int l = 0; l < 719; l++) drive_line(1, 1, 0, 0, 1);
    drive_line(1280, 1279, 1279, 100, 2);
    frame_sync(1'b0);

    // Reset in the middle of a frame
    block_frame(4, 30, 0, 3, 5, 25);
    frame_sync(1'b0);
    block_frame(2, 30, 0, 1, 3, 20);
    do_reset();
    block_frame(3, 30, 0, 2, 3, 20);
    frame_sync(1'b0);
    block_frame(6, 40, 2, 5, 7, 30);
    frame_sync(1'b0);

    repeat (5) pixel(1'b0, 1'b0, 1'b0);
    chk("queue_empty", exp_cyc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
